// File: rtl/digital_tube_if.sv
// CPU bus bundle for the digital tube peripheral.
// Valid/ready semantics: this bus has no ready; a write is accepted on every
// rising clk edge where WE=1, and DEV_RD is valid combinationally for ADDR.
interface digital_tube_if;
   logic [31:0] ADDR;
   logic        WE;
   logic [3:0]  BE;
   logic [31:0] DEV_WD;
   logic [31:0] DEV_RD;

   modport master (output ADDR, output WE, output BE, output DEV_WD, input DEV_RD);
   modport slave  (input ADDR, input WE, input BE, input DEV_WD, output DEV_RD);
endinterface

// File: rtl/digital_tube.sv
// Eight-digit multiplexed seven-segment driver with a DATA/CTRL register pair
// on the CPU bus. Each digit is lit for SCAN_DIV cycles in turn, 0..7.
module digital_tube #(
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset,
   digital_tube_if.slave    bus,
   output logic [7:0]       tube_sel,
   output logic [7:0]       tube_seg
);

   localparam logic [31:0] ADDR_DATA = 32'h0000_7f38;
   localparam logic [31:0] ADDR_CTRL = 32'h0000_7f3c;
   localparam logic [15:0] CNT_MAX   = 16'(SCAN_DIV - 1);

   logic [31:0] data;
   logic        en;
   logic [7:0]  blank;
   logic [15:0] cnt;
   logic [2:0]  dig;
   logic        hit_data;
   logic        hit_ctrl;
   logic [3:0]  nib;
   logic [7:0]  sel_next;
   logic [7:0]  seg_next;

   assign hit_data = (bus.ADDR == ADDR_DATA);
   assign hit_ctrl = (bus.ADDR == ADDR_CTRL);

   // Register file: byte-enabled writes; CTRL keeps only EN and the BLANK mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         data  <= 32'h0;
         en    <= 1'b0;
         blank <= 8'h0;
      end else if (bus.WE) begin
         if (hit_data) begin
            for (int i = 0; i < 4; i++) begin
               if (bus.BE[i]) data[8*i +: 8] <= bus.DEV_WD[8*i +: 8];
            end
         end
         if (hit_ctrl) begin
            if (bus.BE[0]) en    <= bus.DEV_WD[0];
            if (bus.BE[1]) blank <= bus.DEV_WD[15:8];
         end
      end
   end

   // Read mux: unmapped addresses and reserved CTRL bits read as zero.
   always_comb begin
      bus.DEV_RD = 32'h0;
      if (hit_data)      bus.DEV_RD = data;
      else if (hit_ctrl) bus.DEV_RD = {16'h0, blank, 7'h0, en};
   end

   // Scan timebase: free-running, independent of EN and of bus writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 16'h0;
         dig <= 3'd0;
      end else if (cnt == CNT_MAX) begin
         cnt <= 16'h0;
         dig <= dig + 3'd1;
      end else begin
         cnt <= cnt + 16'h1;
      end
   end

   // Digit decode for the current scan position; dark when disabled or blanked.
   always_comb begin
      sel_next = 8'hFF;
      seg_next = 8'hFF;
      nib      = 4'(data >> {dig, 2'b00});
      if (en && !blank[dig]) begin
         sel_next = ~(8'h01 << dig);
         case (nib)
            4'h0: seg_next = 8'hC0;
            4'h1: seg_next = 8'hF9;
            4'h2: seg_next = 8'hA4;
            4'h3: seg_next = 8'hB0;
            4'h4: seg_next = 8'h99;
            4'h5: seg_next = 8'h92;
            4'h6: seg_next = 8'h82;
            4'h7: seg_next = 8'hF8;
            4'h8: seg_next = 8'h80;
            4'h9: seg_next = 8'h90;
            4'hA: seg_next = 8'h88;
            4'hB: seg_next = 8'h83;
            4'hC: seg_next = 8'hC6;
            4'hD: seg_next = 8'hA1;
            4'hE: seg_next = 8'h86;
            default: seg_next = 8'h8E;
         endcase
      end
   end

   // Output register: glitch-free pins, one cycle behind the internal state.
   always_ff @(posedge clk) begin
      if (reset) begin
         tube_sel <= 8'hFF;
         tube_seg <= 8'hFF;
      end else begin
         tube_sel <= sel_next;
         tube_seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_digital_tube.sv
// Self-checking bench for digital_tube: directed scenarios followed by random
// bus traffic, all compared against a cycle-count based reference model.
module tb_digital_tube;

   localparam int SCAN_DIV = 4;
   localparam logic [31:0] A_DATA = 32'h0000_7f38;
   localparam logic [31:0] A_CTRL = 32'h0000_7f3c;
   localparam logic [31:0] A_NONE = 32'h0000_7f40;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic [7:0] tube_sel;
   logic [7:0] tube_seg;

   always #5 clk = ~clk;

   digital_tube_if bus ();

   digital_tube #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .tube_sel (tube_sel),
      .tube_seg (tube_seg)
   );

   // ---------------- reference model ----------------
   logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [31:0] m_data;
   logic [31:0] m_ctrl;
   int          k;        // clock edges since the last reset edge
   logic [7:0]  e_sel;
   logic [7:0]  e_seg;

   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a == A_DATA) return m_data;
      if (a == A_CTRL) return m_ctrl;
      return 32'h0;
   endfunction

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Drive one cycle of inputs, clock it, advance the model, then check.
   task automatic step(input logic rst_i, input logic we_i, input logic [31:0] addr_i,
                       input logic [3:0] be_i, input logic [31:0] wd_i);
      int d;
      reset      = rst_i;
      bus.WE     = we_i;
      bus.ADDR   = addr_i;
      bus.BE     = be_i;
      bus.DEV_WD = wd_i;
      @(posedge clk);
      if (rst_i) begin
         m_data = 32'h0;
         m_ctrl = 32'h0;
         k      = 0;
         e_sel  = 8'hFF;
         e_seg  = 8'hFF;
      end else begin
         d = (k / SCAN_DIV) % 8;
         if (m_ctrl[0] && !m_ctrl[8 + d]) begin
            e_sel = 8'hFF ^ (8'h01 << d);
            e_seg = hex_tab[(m_data >> (4 * d)) & 32'hF];
         end else begin
            e_sel = 8'hFF;
            e_seg = 8'hFF;
         end
         if (we_i && (addr_i == A_DATA || addr_i == A_CTRL)) begin
            logic [31:0] r;
            r = (addr_i == A_DATA) ? m_data : m_ctrl;
            for (int i = 0; i < 4; i++)
               if (be_i[i]) r[8*i +: 8] = wd_i[8*i +: 8];
            if (addr_i == A_DATA) m_data = r;
            else                  m_ctrl = r & 32'h0000_FF01;
         end
         k++;
      end
      #1;
      check("tube_sel", {24'h0, tube_sel}, {24'h0, e_sel});
      check("tube_seg", {24'h0, tube_seg}, {24'h0, e_seg});
      check("dev_rd", bus.DEV_RD, model_rd(addr_i));
   endtask

   task automatic idle(input int n, input logic [31:0] a);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 4'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      step(1'b0, 1'b1, a, be, wd);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      int guard;
      reset = 1'b1;
      bus.WE = 1'b0; bus.ADDR = 32'h0; bus.BE = 4'h0; bus.DEV_WD = 32'h0;

      // reset, including a write that reset must override
      step(1'b1, 1'b0, A_DATA, 4'h0, 32'h0);
      step(1'b1, 1'b1, A_DATA, 4'hF, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, A_CTRL, 4'hF, 32'hFFFF_FFFF);

      // idle after reset: dark, registers read zero
      for (int i = 0; i < 32; i++) begin
         idle(1, A_DATA);
         idle(1, A_CTRL);
      end

      // full scan pattern
      wr(A_DATA, 4'hF, 32'h89AB_CDEF);
      wr(A_CTRL, 4'hF, 32'h0000_0001);
      idle(70, A_CTRL);

      // partial byte write
      wr(A_DATA, 4'hF, 32'h1234_5678);
      wr(A_DATA, 4'b0100, 32'hFFAA_FFFF);
      check("be_merge", bus.DEV_RD, 32'h12AA_5678);
      idle(40, A_DATA);

      // blanking masks
      wr(A_CTRL, 4'hF, 32'h0000_FF01);
      idle(36, A_CTRL);
      wr(A_CTRL, 4'hF, 32'h0000_0F01);
      idle(36, A_CTRL);

      // unmapped write
      wr(A_NONE, 4'hF, 32'hFFFF_FFFF);
      idle(2, A_DATA);
      idle(2, A_CTRL);

      // reset at dig=5, cnt=2, then re-enable
      guard = 0;
      while ((k % (8 * SCAN_DIV)) != 5 * SCAN_DIV + 2 && guard < 64) begin
         idle(1, A_DATA);
         guard++;
      end
      check("align_guard", (guard < 64) ? 32'd1 : 32'd0, 32'd1);
      step(1'b1, 1'b0, A_CTRL, 4'h0, 32'h0);
      check("rst_data", model_rd(A_DATA), 32'h0);
      wr(A_CTRL, 4'h1, 32'h0000_0001);
      idle(2, A_CTRL);
      check("first_lit_sel", {24'h0, tube_sel}, 32'h0000_00FE);
      idle(10, A_DATA);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 4))
            0, 1: a = A_DATA;
            2:    a = A_CTRL;
            3:    a = A_NONE;
            default: a = $urandom();
         endcase
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), a,
              4'($urandom_range(0, 15)), $urandom());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
